// File: rtl/req_arbiter_pkg.sv
// rtl/req_arbiter_pkg.sv - shared types and constants for the request arbiter
package req_arbiter_pkg;

    localparam int NUM_REQ = 16;
    localparam int ID_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OFFER = 2'd1,
        ST_BUSY  = 2'd2
    } arb_state_e;

    function automatic logic [NUM_REQ-1:0] id_onehot(input logic [ID_W-1:0] id);
        logic [NUM_REQ-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    // Bits strictly below id; empty for id 0, which makes round-robin fall back to fixed priority.
    function automatic logic [NUM_REQ-1:0] below_mask(input logic [ID_W-1:0] id);
        logic [NUM_REQ-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            v[i] = (ID_W'(i) < id);
        end
        return v;
    endfunction

endpackage

// File: rtl/req_arbiter_prio_enc16.sv
// rtl/req_arbiter_prio_enc16.sv - 16-bit priority encoder, highest set bit wins
module prio_enc16
    import req_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] vec_i,
    output logic [ID_W-1:0]    idx_o,
    output logic               valid_o
);

    always_comb begin
        idx_o   = '0;
        valid_o = |vec_i;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (vec_i[i]) begin
                idx_o = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/req_arbiter.sv
// rtl/req_arbiter.sv - 16-way request arbiter with grant handshake and busy watchdog
module req_arbiter
    import req_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] mask,
    input  logic               rr_mode,
    input  logic               gnt_ready,
    input  logic               done,
    output logic               gnt_valid,
    output logic [ID_W-1:0]    gnt_id,
    output logic               busy,
    output logic               timeout,
    output logic               pend_any
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] pending_q, pending_d;
    logic [ID_W-1:0]    last_id_q, last_id_d;
    logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               timeout_q, timeout_d;

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] below;
    logic [NUM_REQ-1:0] clr;
    logic [ID_W-1:0]    below_idx, all_idx, sel_id;
    logic               below_valid, all_valid;
    logic               accept;

    assign eligible = pending_q & ~mask;
    assign below    = eligible & below_mask(last_id_q);

    prio_enc16 u_enc_below (
        .vec_i   (below),
        .idx_o   (below_idx),
        .valid_o (below_valid)
    );

    prio_enc16 u_enc_all (
        .vec_i   (eligible),
        .idx_o   (all_idx),
        .valid_o (all_valid)
    );

    assign sel_id = (rr_mode && below_valid) ? below_idx : all_idx;
    assign accept = (state_q == ST_OFFER) && gnt_ready;
    assign clr    = accept ? id_onehot(gnt_id_q) : '0;

    // New requests are applied after the clear so a same-cycle re-request survives.
    assign pending_d = (pending_q & ~clr) | (req & ~mask);

    always_comb begin
        state_d   = state_q;
        gnt_id_d  = gnt_id_q;
        last_id_d = last_id_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ena && all_valid) begin
                    state_d  = ST_OFFER;
                    gnt_id_d = sel_id;
                end
            end
            ST_OFFER: begin
                if (gnt_ready) begin
                    state_d   = ST_BUSY;
                    cnt_d     = 8'd0;
                    last_id_d = gnt_id_q;
                end
            end
            ST_BUSY: begin
                if (done) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            last_id_q <= '0;
            gnt_id_q  <= '0;
            cnt_q     <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            last_id_q <= last_id_d;
            gnt_id_q  <= gnt_id_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt_valid = (state_q == ST_OFFER);
    assign busy      = (state_q == ST_BUSY);
    assign gnt_id    = gnt_id_q;
    assign timeout   = timeout_q;
    assign pend_any  = |eligible;

endmodule

// File: tb/tb_req_arbiter.sv
// tb/tb_req_arbiter.sv - scoreboard bench for req_arbiter
module tb_req_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic [15:0] req;
    logic [15:0] mask;
    logic        rr_mode;
    logic        gnt_ready;
    logic        done;
    logic        gnt_valid;
    logic [3:0]  gnt_id;
    logic        busy;
    logic        timeout;
    logic        pend_any;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [3:0]  exp_q[$];
    logic [3:0]  mon_exp;

    always #5 clk = ~clk;

    req_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .req       (req),
        .mask      (mask),
        .rr_mode   (rr_mode),
        .gnt_ready (gnt_ready),
        .done      (done),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .busy      (busy),
        .timeout   (timeout),
        .pend_any  (pend_any)
    );

    // Every accepted grant is matched against the next expected id.
    always @(negedge clk) begin
        if (rst_n && gnt_valid && gnt_ready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_grant: got id %0d, expected no grant", gnt_id);
            end else begin
                mon_exp = exp_q.pop_front();
                if (gnt_id !== mon_exp) begin
                    n_fail++;
                    $display("FAIL grant_order: got id %0d, expected id %0d", gnt_id, mon_exp);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_busy(input string name);
        int k;
        k = 0;
        while (!busy && k < 20) begin
            tick();
            k++;
        end
        check(name, busy, 1);
    endtask

    task automatic run_busy(input string name, input int n);
        for (int i = 1; i <= n; i++) begin
            check(name, busy, 1);
            if (i == n) done = 1'b1;
            tick();
            done = 1'b0;
        end
    endtask

    task automatic serve_one(input string name, input int n);
        wait_busy(name);
        run_busy(name, n);
        check(name, busy, 0);
    endtask

    initial begin
        int k;
        rst_n     = 1'b0;
        ena       = 1'b1;
        req       = '0;
        mask      = '0;
        rr_mode   = 1'b0;
        gnt_ready = 1'b1;
        done      = 1'b0;
        tick();
        tick();
        check("rst_gnt_valid", gnt_valid, 0);
        check("rst_gnt_id", gnt_id, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout", timeout, 0);
        check("rst_pend_any", pend_any, 0);
        rst_n = 1'b1;
        tick();

        // Single request: one-cycle latency, three busy cycles, pending cleared
        exp_q.push_back(4'd4);
        req = 16'h0010;
        tick();
        req = '0;
        check("t1_no_offer_yet", gnt_valid, 0);
        check("t1_pend_any", pend_any, 1);
        tick();
        check("t1_offer", gnt_valid, 1);
        check("t1_gnt_id", gnt_id, 4);
        tick();
        check("t1_busy", busy, 1);
        check("t1_pending_cleared", pend_any, 0);
        run_busy("t1_busy_len", 3);
        check("t1_idle", busy, 0);
        check("t1_id_hold", gnt_id, 4);

        // Fixed priority: 15 before 0
        exp_q.push_back(4'd15);
        exp_q.push_back(4'd0);
        req = 16'h8001;
        tick();
        req = '0;
        serve_one("t2_first", 2);
        serve_one("t2_second", 2);
        check("t2_drained", pend_any, 0);

        // Round-robin with requests held: 15, 1, 0, 15
        rr_mode = 1'b1;
        exp_q.push_back(4'd15);
        exp_q.push_back(4'd1);
        exp_q.push_back(4'd0);
        exp_q.push_back(4'd15);
        req = 16'h8003;
        serve_one("t3_rr_a", 1);
        serve_one("t3_rr_b", 1);
        serve_one("t3_rr_c", 1);
        serve_one("t3_rr_d", 1);
        ena = 1'b0;
        req = '0;
        tick();
        tick();
        tick();
        check("t3_ena_blocks", gnt_valid, 0);
        check("t3_pending_kept", pend_any, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t3_async_clear", pend_any, 0);
        tick();
        rst_n   = 1'b1;
        ena     = 1'b1;
        rr_mode = 1'b0;
        tick();

        // Watchdog expiry four cycles after accept
        exp_q.push_back(4'd9);
        req = 16'h0200;
        tick();
        req = '0;
        wait_busy("t4_busy");
        k = 0;
        while (k < 8) begin
            tick();
            k++;
            if (timeout) break;
        end
        check("t4_timeout_latency", k, 4);
        check("t4_idle_on_expiry", busy, 0);
        tick();
        check("t4_pulse_one_cycle", timeout, 0);

        // done on the expiry cycle wins
        exp_q.push_back(4'd9);
        req = 16'h0200;
        tick();
        req = '0;
        wait_busy("t4b_busy");
        run_busy("t4b_busy_len", 4);
        check("t4b_no_timeout", timeout, 0);
        check("t4b_idle", busy, 0);
        tick();
        check("t4b_no_timeout_late", timeout, 0);

        // Masked request never pends; an offer is held while not ready
        mask = 16'h0004;
        req  = 16'h0004;
        tick();
        req = '0;
        tick();
        check("t5_masked_pend_any", pend_any, 0);
        check("t5_masked_no_offer", gnt_valid, 0);
        tick();
        check("t5_masked_no_offer2", gnt_valid, 0);
        mask      = '0;
        gnt_ready = 1'b0;
        exp_q.push_back(4'd5);
        req = 16'h0020;
        tick();
        req = '0;
        k = 0;
        while (!gnt_valid && k < 10) begin
            tick();
            k++;
        end
        check("t5_offer_seen", gnt_valid, 1);
        exp_q.push_back(4'd15);
        for (int i = 0; i < 4; i++) begin
            mask = i[0] ? 16'h0000 : 16'h0020;
            ena  = 1'b0;
            req  = 16'h8000;
            tick();
            check("t5_offer_held", gnt_valid, 1);
            check("t5_offer_id_stable", gnt_id, 5);
        end
        req       = '0;
        mask      = '0;
        ena       = 1'b1;
        gnt_ready = 1'b1;
        tick();
        run_busy("t5_accepted", 1);
        serve_one("t5_next", 1);

        // Reset during BUSY abandons the transaction
        exp_q.push_back(4'd8);
        req = 16'h0100;
        tick();
        req = '0;
        wait_busy("t6_busy");
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_busy_cleared", busy, 0);
        check("t6_gnt_valid", gnt_valid, 0);
        check("t6_gnt_id", gnt_id, 0);
        check("t6_timeout", timeout, 0);
        check("t6_pend_any", pend_any, 0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t6_no_grant", gnt_valid | timeout | busy, 0);
        end

        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/req_arbiter.md
REQ_ARBITER -- requirements
Module: req_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL set BUSY-state watchdog limit in cycles (legal range 1..255, 8-bit counter).
REQ-002 Port clk  input  1  SHALL be the sole clock; all state updates on rising edge.
REQ-003 Port rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 Port ena  input  1  SHALL enable issuing new grants when high.
REQ-005 Port req  input  16  SHALL carry request pulses; bit i = requester i.
REQ-006 Port mask  input  16  SHALL block requester i from capture and selection when bit i high.
REQ-007 Port rr_mode  input  1  SHALL select round-robin (1) or fixed priority (0).
REQ-008 Port gnt_ready  input  1  SHALL signal that the consumer accepts the offered grant.
REQ-009 Port done  input  1  SHALL signal that the granted transaction has completed.
REQ-010 Port gnt_valid  output  1  SHALL indicate that a grant is offered.
REQ-011 Port gnt_id  output  4  SHALL carry the offered or active requester index.
REQ-012 Port busy  output  1  SHALL be high while in BUSY.
REQ-013 Port timeout  output  1  SHALL pulse for one cycle on watchdog expiry.
REQ-014 Port pend_any  output  1  SHALL be high when any unmasked pending bit is set.

Function
REQ-015 pending[15:0] next SHALL = (pending & ~clr) | (req & ~mask); clr = one-hot of gnt_id on the accept cycle; set wins over clear for the same bit.
REQ-016 Eligible set SHALL = pending & ~mask, evaluated in IDLE only.
REQ-017 Fixed priority SHALL select the highest eligible index (15 highest, 0 lowest).
REQ-018 Round-robin SHALL select the highest eligible index below last_id; if none, the highest eligible overall; last_id = 0 is therefore equivalent to fixed priority.
REQ-019 last_id SHALL update to gnt_id on accept (gnt_valid & gnt_ready), in both modes.
REQ-020 FSM states SHALL be IDLE, OFFER, BUSY.
REQ-021 IDLE->OFFER SHALL occur when ena=1 and eligible != 0; gnt_id latched on the same edge; gnt_valid high from the next cycle (1-cycle latency from pending to offer).
REQ-022 OFFER SHALL hold gnt_valid=1 and gnt_id stable until gnt_ready=1; mask/ena/req changes SHALL NOT withdraw or alter the offer.
REQ-023 OFFER->BUSY SHALL occur on gnt_ready=1: clear the pending bit, load watchdog counter to 0, deassert gnt_valid.
REQ-024 BUSY->IDLE SHALL occur on done=1; done outside BUSY is ignored.
REQ-025 In BUSY the counter SHALL increment each cycle; when it reaches TIMEOUT_CYCLES without done, FSM SHALL go to IDLE and timeout SHALL pulse one cycle.
REQ-026 If done and expiry coincide, done SHALL win (no timeout pulse).
REQ-027 ena=0 SHALL block only IDLE->OFFER; OFFER and BUSY SHALL complete normally; pending capture SHALL continue.
REQ-028 Back-to-back: BUSY->IDLE followed by OFFER on the next edge when eligible != 0 (minimum 1 IDLE cycle).
REQ-029 gnt_id SHALL hold its last value in IDLE.

Reset
REQ-030 rst_n low SHALL force immediately: state=IDLE, pending=0, last_id=0, counter=0, gnt_id=0, gnt_valid=0, busy=0, timeout=0.
REQ-031 Reset asserted mid-OFFER or mid-BUSY SHALL abandon the transaction with no timeout pulse; no grant issued before the first edge after release.

Structure
REQ-032 Shared package SHALL hold the state encoding (IDLE/OFFER/BUSY), requester count 16, and ID width 4.
REQ-033 A combinational sub-module prio_enc16 (16-bit in -> 4-bit index + valid, highest bit wins) SHALL be instantiated twice: below-last_id candidates and full eligible set.

Verification
REQ-034 req=0x0010 pulse, ready tied high, done after 3 cycles -> gnt_valid one cycle later, gnt_id=4, busy 3 cycles, pending[4] cleared.
REQ-035 req=0x8001 same cycle, rr_mode=0 -> grant 15 then 0, each after its done.
REQ-036 rr_mode=1, pending 0x8003 held via repeated pulses -> grant order 15, 1, 0, 15.
REQ-037 TIMEOUT_CYCLES=4, grant accepted, no done -> timeout pulse exactly 4 cycles after accept, return to IDLE; done on expiry cycle -> no pulse.
REQ-038 mask=0x0004, req=0x0004 -> no grant, pend_any=0; offer stays stable while gnt_ready=0 and mask toggles.
REQ-039 rst_n low during BUSY -> all outputs 0 asynchronously; after release with pending cleared, no grant.
